// File: rtl/vga_sync_gen.sv
// VGA timing generator: h/v counters, sync decode and a registered
// TinyVGA PMOD output word with colour blanked outside the visible area.
module vga_sync_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FRONT  = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BACK   = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FRONT  = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BACK   = 33
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [5:0] rgb_in,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       display_on,
  output logic       frame_start,
  output logic [7:0] uo_out
);

  localparam int unsigned CW      = 10;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CW-1:0] H_LAST  = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST  = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS   = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_VIS   = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG  = CW'(H_ACTIVE + H_FRONT);
  localparam logic [CW-1:0] HS_END  = CW'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [CW-1:0] VS_BEG  = CW'(V_ACTIVE + V_FRONT);
  localparam logic [CW-1:0] VS_END  = CW'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [7:0]    UO_IDLE = 8'h88;

  logic [CW-1:0] h;
  logic [CW-1:0] v;
  logic [CW-1:0] h_next;
  logic [CW-1:0] v_next;
  logic          hsync_raw;
  logic          vsync_raw;
  logic [7:0]    pix;

  // Next counter values: h wraps at end of line, v steps only on that wrap.
  always_comb begin
    h_next = h + CW'(1);
    v_next = v;
    if (h == H_LAST) begin
      h_next = '0;
      if (v == V_LAST) begin
        v_next = '0;
      end else begin
        v_next = v + CW'(1);
      end
    end
  end

  // Position decode: visible area, frame origin and active-low syncs.
  always_comb begin
    hpos        = h;
    vpos        = v;
    display_on  = (h < H_VIS) && (v < V_VIS);
    frame_start = (h == '0) && (v == '0);
    hsync_raw   = !((h >= HS_BEG) && (h < HS_END));
    vsync_raw   = !((v >= VS_BEG) && (v < VS_END));
  end

  // PMOD word: {hs, B0, G0, R0, vs, B1, G1, R1}; colour forced to 0 when blanked.
  always_comb begin
    pix = {hsync_raw, 3'b000, vsync_raw, 3'b000};
    if (display_on) begin
      pix[6] = rgb_in[0];
      pix[5] = rgb_in[2];
      pix[4] = rgb_in[4];
      pix[2] = rgb_in[1];
      pix[1] = rgb_in[3];
      pix[0] = rgb_in[5];
    end
  end

  // Counters and output register; reset wins over ena, ena low freezes all.
  always_ff @(posedge clk) begin
    if (rst) begin
      h      <= '0;
      v      <= '0;
      uo_out <= UO_IDLE;
    end else if (ena) begin
      h      <= h_next;
      v      <= v_next;
      uo_out <= pix;
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen. Horizontal timing uses the 640x480
// defaults; the vertical timing is shortened (12/2/2/3 -> 19 lines,
// 15200 clocks per frame) so two whole frames fit in a short run.
module tb_vga_sync_gen;

  localparam int unsigned VA    = 12;
  localparam int unsigned VF    = 2;
  localparam int unsigned VS    = 2;
  localparam int unsigned VB    = 3;
  localparam int unsigned HT    = 800;
  localparam int unsigned VT    = 19;
  localparam int unsigned FRAME = HT * VT;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic [5:0] rgb_in;
  logic [9:0] hpos;
  logic [9:0] vpos;
  logic       display_on;
  logic       frame_start;
  logic [7:0] uo_out;

  int checks   = 0;
  int failures = 0;

  vga_sync_gen #(
    .V_ACTIVE(VA),
    .V_FRONT (VF),
    .V_SYNC  (VS),
    .V_BACK  (VB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .rgb_in     (rgb_in),
    .hpos       (hpos),
    .vpos       (vpos),
    .display_on (display_on),
    .frame_start(frame_start),
    .uo_out     (uo_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic seek(input int unsigned th, input int unsigned tv, input string tag);
    int n;
    n = 0;
    while (!(32'(hpos) == th && 32'(vpos) == tv) && n < 20000) begin
      tick();
      n++;
    end
    check(tag, 32'(32'(hpos) == th && 32'(vpos) == tv), 32'd1);
  endtask

  initial begin
    int unsigned mh, mv, cap_h, cap_v;
    logic        disp_cap, hs_exp, vs_exp;
    logic [7:0]  exp_uo;
    int pos_err, disp_err, fs_err, uo_err, vis_err, blank_err;
    int hs_falls, hs_runs, hs_bad, hs_low, hs_last;
    int vs_falls, vs_runs, vs_bad, vs_low;
    int fs_n, fs_first, fs_period;
    logic prev_hs, prev_vs;

    rst    = 1'b1;
    ena    = 1'b0;
    rgb_in = 6'h3F;

    // Reset held 3 clocks with ena low.
    repeat (3) tick();
    check("rst_uo",    32'(uo_out),      32'h88);
    check("rst_hpos",  32'(hpos),        32'd0);
    check("rst_vpos",  32'(vpos),        32'd0);
    check("rst_disp",  32'(display_on),  32'd1);
    check("rst_fs",    32'(frame_start), 32'd1);

    rst = 1'b0;
    ena = 1'b1;
    #1;
    check("rel_hpos", 32'(hpos),        32'd0);
    check("rel_fs",   32'(frame_start), 32'd1);

    // Two full frames plus one clock, tracked against a position model.
    mh = 0; mv = 0;
    pos_err = 0; disp_err = 0; fs_err = 0; uo_err = 0; vis_err = 0; blank_err = 0;
    hs_falls = 0; hs_runs = 0; hs_bad = 0; hs_low = 0; hs_last = -1;
    vs_falls = 0; vs_runs = 0; vs_bad = 0; vs_low = 0;
    fs_n = 0; fs_first = 0; fs_period = 0;
    prev_hs = 1'b1; prev_vs = 1'b1;

    for (int c = 1; c <= 2 * int'(FRAME) + 1; c++) begin
      cap_h = mh;
      cap_v = mv;
      tick();
      if (mh == HT - 1) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end else begin
        mh = mh + 1;
      end

      if (c <= 3) begin
        check($sformatf("count_h%0d", c), 32'(hpos),        32'(c));
        check($sformatf("count_fs%0d", c), 32'(frame_start), 32'd0);
      end

      if (32'(hpos) != mh || 32'(vpos) != mv) pos_err++;
      if (display_on !== (mh < 640 && mv < VA)) disp_err++;
      if (frame_start !== (mh == 0 && mv == 0)) fs_err++;

      disp_cap = (cap_h < 640) && (cap_v < VA);
      hs_exp   = !(cap_h >= 656 && cap_h < 752);
      vs_exp   = !(cap_v >= 14 && cap_v < 16);
      exp_uo   = 8'h00;
      if (hs_exp)   exp_uo = exp_uo | 8'h80;
      if (vs_exp)   exp_uo = exp_uo | 8'h08;
      if (disp_cap) exp_uo = exp_uo | 8'h77;
      if (uo_out !== exp_uo) uo_err++;
      if (disp_cap && (uo_out & 8'h77) !== 8'h77) vis_err++;
      if (!disp_cap && (uo_out & 8'h77) !== 8'h00) blank_err++;

      if (uo_out[7] == 1'b0) begin
        if (prev_hs) begin
          hs_falls++;
          if (cap_h != 656) hs_bad++;
          if (hs_last >= 0 && c - hs_last != 800) hs_bad++;
          hs_last = c;
        end
        hs_low++;
      end else if (!prev_hs) begin
        hs_runs++;
        if (hs_low != 96) hs_bad++;
        hs_low = 0;
      end
      prev_hs = uo_out[7];

      if (uo_out[3] == 1'b0) begin
        if (prev_vs) begin
          vs_falls++;
          if (cap_h != 0 || cap_v != 14) vs_bad++;
        end
        vs_low++;
      end else if (!prev_vs) begin
        vs_runs++;
        if (vs_low != 1600) vs_bad++;
        vs_low = 0;
      end
      prev_vs = uo_out[3];

      if (frame_start) begin
        fs_n++;
        if (fs_n == 1) fs_first = c;
        else if (fs_n == 2) fs_period = c - fs_first;
      end
    end

    check("pos_track",   32'(pos_err),   32'd0);
    check("disp_track",  32'(disp_err),  32'd0);
    check("fs_track",    32'(fs_err),    32'd0);
    check("uo_track",    32'(uo_err),    32'd0);
    check("pix_visible", 32'(vis_err),   32'd0);
    check("pix_blank",   32'(blank_err), 32'd0);
    check("hs_falls",    32'(hs_falls),  32'd38);
    check("hs_runs",     32'(hs_runs),   32'd38);
    check("hs_bad",      32'(hs_bad),    32'd0);
    check("vs_falls",    32'(vs_falls),  32'd2);
    check("vs_runs",     32'(vs_runs),   32'd2);
    check("vs_bad",      32'(vs_bad),    32'd0);
    check("fs_count",    32'(fs_n),      32'd2);
    check("fs_first",    32'(fs_first),  32'd15200);
    check("fs_period",   32'(fs_period), 32'd15200);

    // Freeze at (100,5); last capture was (99,5), visible, full white.
    seek(100, 5, "seek_100_5");
    check("pre_freeze_uo", 32'(uo_out), 32'hFF);
    ena    = 1'b0;
    rgb_in = 6'h00;
    repeat (5) tick();
    check("freeze5_hpos", 32'(hpos), 32'd100);
    repeat (5) tick();
    check("freeze_hpos", 32'(hpos),   32'd100);
    check("freeze_vpos", 32'(vpos),   32'd5);
    check("freeze_uo",   32'(uo_out), 32'hFF);

    // Resume with distinct colour patterns to pin the bit mapping.
    ena    = 1'b1;
    rgb_in = 6'h26;
    tick();
    check("resume_hpos", 32'(hpos),   32'd101);
    check("map_26",      32'(uo_out), 32'hAD);
    rgb_in = 6'h19;
    tick();
    check("resume_hpos2", 32'(hpos),   32'd102);
    check("map_19",       32'(uo_out), 32'hDA);

    // Single-clock reset in mid-frame.
    seek(300, 10, "seek_300_10");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_hpos", 32'(hpos),        32'd0);
    check("mid_rst_vpos", 32'(vpos),        32'd0);
    check("mid_rst_uo",   32'(uo_out),      32'h88);
    check("mid_rst_fs",   32'(frame_start), 32'd1);
    tick();
    check("post_rst_hpos", 32'(hpos),   32'd1);
    check("post_rst_uo",   32'(uo_out), 32'hDA);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
